// File: rtl/hdmi_vram_arbiter.sv
// hdmi_vram_arbiter
// Shares one single-port, byte-writable VRAM block RAM between an AXI4-Lite
// host path and the video character fetch engine. Video normally wins, and a
// streak counter bounds how long a pending host access can be passed over.
//
// Request/acknowledge contract (both requesters): a requester raises req and
// holds it, with its address/data stable, until it sees a one-cycle ack. The
// access is issued to the RAM in the grant cycle N (mem_* driven
// combinationally) and acknowledged with registered ack in cycle N+1, where
// rdata is valid only while ack is high. A requester is never granted in the
// same cycle it is being acknowledged, so keeping req high through the ack
// cycle does not start a second access.

module hdmi_vram_arbiter #(
    parameter int NUM_WORDS      = 600,
    parameter int ADDR_W         = 10,
    parameter int MAX_VID_STREAK = 4
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    // host side
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    input  logic [3:0]        host_wstrb,
    output logic              host_ack,
    output logic [31:0]       host_rdata,
    output logic              host_err,
    // video side
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [31:0]       vid_rdata,
    // block RAM port
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_VID_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

    // outstanding flags double as the registered ack pulses
    logic                r_host_out;
    logic                r_vid_out;
    logic                r_host_err;
    logic                r_host_rd;
    logic [STREAK_W-1:0] r_streak;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [31:0]         r_last_wdata;

    logic                w_host_elig;
    logic                w_vid_elig;
    logic                w_streak_full;
    logic                w_grant_vid;
    logic                w_grant_host;
    logic                w_host_in_range;
    logic [STREAK_W-1:0] w_streak_next;

    // eligibility and priority decision for the current cycle; no grant is
    // ever made while reset is asserted so every output reads 0 in reset
    always_comb begin
        w_host_elig     = host_req & ~r_host_out;
        w_vid_elig      = vid_req & ~r_vid_out;
        w_streak_full   = (r_streak >= STREAK_MAX);
        w_grant_vid     = axi_aresetn & w_vid_elig & (~w_host_elig | ~w_streak_full);
        w_grant_host    = axi_aresetn & w_host_elig & ~w_grant_vid;
        w_host_in_range = ({{(32-ADDR_W){1'b0}}, host_addr} < 32'(NUM_WORDS));
    end

    // RAM port drive: address/data hold their last granted values when idle;
    // an out-of-range host access is granted but never enables the RAM
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = r_last_addr;
        mem_wdata = r_last_wdata;
        if (w_grant_vid) begin
            mem_en   = 1'b1;
            mem_addr = vid_addr;
        end else if (w_grant_host) begin
            mem_addr = host_addr;
            if (w_host_in_range) begin
                mem_en = 1'b1;
                if (host_we) begin
                    mem_we    = host_wstrb;
                    mem_wdata = host_wdata;
                end
            end
        end
    end

    // streak counter next value: counts video wins over an eligible host,
    // saturating; any host grant or an idle host clears it
    always_comb begin
        w_streak_next = r_streak;
        if (w_grant_host || !host_req) begin
            w_streak_next = '0;
        end else if (w_grant_vid && w_host_elig && !w_streak_full) begin
            w_streak_next = r_streak + 1'b1;
        end
    end

    // completion stage: register which requester was granted and how
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_host_out <= 1'b0;
            r_vid_out  <= 1'b0;
            r_host_err <= 1'b0;
            r_host_rd  <= 1'b0;
        end else begin
            r_host_out <= w_grant_host;
            r_vid_out  <= w_grant_vid;
            r_host_err <= w_grant_host & ~w_host_in_range;
            r_host_rd  <= w_grant_host & ~host_we & w_host_in_range;
        end
    end

    // streak counter register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_streak <= '0;
        end else begin
            r_streak <= w_streak_next;
        end
    end

    // remember the last address/data put on the RAM port for idle cycles
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else if (w_grant_vid || w_grant_host) begin
            r_last_addr  <= mem_addr;
            r_last_wdata <= mem_wdata;
        end
    end

    // ack/data outputs; RAM read data arrives in the ack cycle
    always_comb begin
        host_ack   = r_host_out;
        host_err   = r_host_err;
        host_rdata = r_host_rd ? mem_rdata : 32'h0;
        vid_ack    = r_vid_out;
        vid_rdata  = r_vid_out ? mem_rdata : 32'h0;
    end

endmodule
